half_life_meter: RTL and testbench
==================================

HALF_LIFE_METER -- requirements
Module: half_life_meter

Interface
REQ-001 Parameter N, default 8: sample width in bits.
REQ-002 Parameter CW, default 16: elapsed-cycle counter width in bits.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-low; sampled on the rising clk edge only.
REQ-005 start  input  1  arms one measurement; honoured only in IDLE.
REQ-006 sample_valid  input  1  qualifies sample this cycle.
REQ-007 sample  input  N  decaying level under measurement, unsigned.
REQ-008 busy  output  1  high in ARM and MEASURE.
REQ-009 done  output  1  one-cycle pulse when a result is published.
REQ-010 timeout  output  1  result flag: counter saturated before the crossing; held until next accepted start.
REQ-011 err  output  1  result flag: reference level was 0; held until next accepted start.
REQ-012 half_life  output  CW  elapsed cycles from reference sample to crossing sample; held until next accepted start.
REQ-013 ref_level  output  N  captured reference R; held until next accepted start.

Function
REQ-014 FSM states: IDLE, ARM, MEASURE, DONE; exactly one state active.
REQ-015 IDLE: start=1 -> ARM next cycle; clear timeout, err, half_life, ref_level to 0 on that same edge.
REQ-016 ARM: first cycle with sample_valid=1 -> capture R=sample, T=R>>1 (floor); go to MEASURE, elapsed count = 0.
REQ-017 ARM with captured R=0 -> go to DONE; err=1, half_life=0, timeout=0.
REQ-018 MEASURE: elapsed count increments by 1 each clk cycle regardless of sample_valid.
REQ-019 Crossing: cycle with sample_valid=1 and sample <= T; half_life = cycle index of crossing minus cycle index of reference capture; go to DONE.
REQ-020 Samples above R are ignored; no re-referencing.
REQ-021 Saturation: elapsed reaches 2^CW-1 with no crossing -> DONE, timeout=1, half_life=2^CW-1.
REQ-022 Crossing on the same cycle as saturation: crossing wins; timeout=0, half_life=2^CW-1.
REQ-023 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-024 Latency: result registers and done valid on the cycle after the crossing/saturation/zero-reference cycle.
REQ-025 start while busy or in DONE is ignored (no restart, no queuing).
REQ-026 Arithmetic: unsigned compares; counter never wraps.

Reset
REQ-027 rst=0 at a rising edge -> IDLE; busy, done, timeout, err = 0; half_life, ref_level = 0; counter = 0.
REQ-028 Reset mid-ARM/MEASURE aborts the measurement with no done pulse; inputs ignored while rst=0.
REQ-029 First start is honoured on the first edge with rst=1.

Structure
REQ-030 Package half_life_pkg holds the FSM state enumeration and default N and CW constants.
REQ-031 One sub-module sat_counter (CW-bit, clear, enable, saturate flag) implements the elapsed counter.

Verification
REQ-032 rst=0 for 3 cycles with start=1 and random samples -> all outputs 0, busy=0, no done.
REQ-033 start; samples valid every cycle 200,190,170,150,120,100 -> done 1 cycle after 100; half_life=5, ref_level=200, timeout=0, err=0.
REQ-034 Odd reference 201 (T=100): sample 101 no crossing; next-cycle 100 -> half_life=2 when 101 was cycle 1 and 100 was cycle 2.
REQ-035 Reference sample 0 -> done next cycle, err=1, half_life=0, busy drops.
REQ-036 CW=4, R=50, samples held at 40 -> done after saturation, timeout=1, half_life=15; repeat with sample 25 at elapsed 15 -> timeout=0, half_life=15.
REQ-037 rst=0 at elapsed 3 of a measurement -> no done, IDLE; start pulsed mid-MEASURE -> ignored, original half_life unchanged.

Source files
------------

// File: rtl/half_life_pkg.sv
// Shared definitions for the half-life meter: FSM state encoding and default widths.
package half_life_pkg;

  localparam int N_DEF  = 8;
  localparam int CW_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Elapsed-cycle counter that clears, counts up on enable and sticks at all-ones.
module sat_counter #(
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          sat
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign sat   = &count_q;
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !sat) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/half_life_meter.sv
// Measures cycles from a reference sample R until the level first falls to floor(R/2) or below.
module half_life_meter
  import half_life_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          sample_valid,
  input  logic [N-1:0]  sample,
  output logic          busy,
  output logic          done,
  output logic          timeout,
  output logic          err,
  output logic [CW-1:0] half_life,
  output logic [N-1:0]  ref_level
);

  state_e        state_q, state_d;
  logic          timeout_q, timeout_d;
  logic          err_q, err_d;
  logic [CW-1:0] half_life_q, half_life_d;
  logic [N-1:0]  ref_level_q, ref_level_d;
  logic [N-1:0]  thr_q, thr_d;

  logic          cnt_clr;
  logic          cnt_en;
  logic [CW-1:0] cnt;
  logic          cnt_sat;

  // Counter reads 1 on the first MEASURE cycle so its value equals elapsed cycles since capture.
  sat_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .sat   (cnt_sat)
  );

  always_comb begin
    state_d     = state_q;
    timeout_d   = timeout_q;
    err_d       = err_q;
    half_life_d = half_life_q;
    ref_level_d = ref_level_q;
    thr_d       = thr_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (start) begin
          state_d     = ST_ARM;
          timeout_d   = 1'b0;
          err_d       = 1'b0;
          half_life_d = '0;
          ref_level_d = '0;
        end
      end
      ST_ARM: begin
        if (sample_valid) begin
          ref_level_d = sample;
          thr_d       = sample >> 1;
          if (sample == '0) begin
            err_d       = 1'b1;
            timeout_d   = 1'b0;
            half_life_d = '0;
            state_d     = ST_DONE;
          end else begin
            cnt_en  = 1'b1;
            state_d = ST_MEASURE;
          end
        end
      end
      ST_MEASURE: begin
        cnt_en = 1'b1;
        // A crossing on the saturation cycle still counts as a crossing.
        if (sample_valid && (sample <= thr_q)) begin
          half_life_d = cnt;
          timeout_d   = 1'b0;
          state_d     = ST_DONE;
        end else if (cnt_sat) begin
          half_life_d = cnt;
          timeout_d   = 1'b1;
          state_d     = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
      half_life_q <= '0;
      ref_level_q <= '0;
      thr_q       <= '0;
    end else begin
      state_q     <= state_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
      half_life_q <= half_life_d;
      ref_level_q <= ref_level_d;
      thr_q       <= thr_d;
    end
  end

  assign busy      = (state_q == ST_ARM) || (state_q == ST_MEASURE);
  assign done      = (state_q == ST_DONE);
  assign timeout   = timeout_q;
  assign err       = err_q;
  assign half_life = half_life_q;
  assign ref_level = ref_level_q;

endmodule

// File: tb/tb_half_life_meter.sv
// Bench for half_life_meter: two instances (CW=16 and CW=4) share stimulus and are checked each cycle.
module tb_half_life_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sample_valid;
  logic [7:0] sample;

  logic        b16, d16, to16, e16;
  logic [15:0] hl16;
  logic [7:0]  rl16;
  logic        b4, d4, to4, e4;
  logic [3:0]  hl4;
  logic [7:0]  rl4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  half_life_meter #(.N(8), .CW(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .sample(sample),
    .busy(b16), .done(d16), .timeout(to16), .err(e16), .half_life(hl16), .ref_level(rl16)
  );

  half_life_meter #(.N(8), .CW(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .sample_valid(sample_valid), .sample(sample),
    .busy(b4), .done(d4), .timeout(to4), .err(e4), .half_life(hl4), .ref_level(rl4)
  );

  // Reference model: one measurement per instance, timed by absolute cycle numbers.
  int m_mode[2];     // 0 idle, 1 waiting for reference, 2 measuring, 3 publishing
  int m_ref_cyc[2];
  int m_thr[2];
  int m_ref[2];
  int m_hl[2];
  int m_to[2];
  int m_err[2];
  int m_max[2] = '{65535, 15};
  int cyc = 0;

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (!rst) begin
        m_mode[k] = 0; m_ref[k] = 0; m_hl[k] = 0; m_to[k] = 0; m_err[k] = 0;
      end else begin
        case (m_mode[k])
          0: if (start) begin
            m_mode[k] = 1; m_ref[k] = 0; m_hl[k] = 0; m_to[k] = 0; m_err[k] = 0;
          end
          1: if (sample_valid) begin
            m_ref[k] = int'(sample);
            if (sample == 0) begin
              m_err[k] = 1; m_hl[k] = 0; m_to[k] = 0; m_mode[k] = 3;
            end else begin
              m_thr[k] = int'(sample) / 2; m_ref_cyc[k] = cyc; m_mode[k] = 2;
            end
          end
          2: begin
            int el;
            el = cyc - m_ref_cyc[k];
            if (sample_valid && int'(sample) <= m_thr[k]) begin
              m_hl[k] = el; m_to[k] = 0; m_mode[k] = 3;
            end else if (el >= m_max[k]) begin
              m_hl[k] = m_max[k]; m_to[k] = 1; m_mode[k] = 3;
            end
          end
          default: m_mode[k] = 0;
        endcase
      end
    end
    cyc++;
  endtask

  function automatic longint unsigned pack(input int bz, input int dn, input int t, input int e,
                                           input int hl, input int rl);
    return (longint'(bz) << 27) | (longint'(dn) << 26) | (longint'(t) << 25) |
           (longint'(e) << 24) | (longint'(hl) << 8) | longint'(rl);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      longint unsigned exp, act;
      exp = pack((m_mode[k] == 1 || m_mode[k] == 2) ? 1 : 0, (m_mode[k] == 3) ? 1 : 0,
                 m_to[k], m_err[k], m_hl[k], m_ref[k]);
      if (k == 0) act = pack(int'(b16), int'(d16), int'(to16), int'(e16), int'(hl16), int'(rl16));
      else        act = pack(int'(b4), int'(d4), int'(to4), int'(e4), int'(hl4), int'(rl4));
      chk(k == 0 ? "model_cw16" : "model_cw4", act, exp);
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic st, input logic sv, input logic [7:0] s);
    start = st; sample_valid = sv; sample = s;
    step();
  endtask

  typedef struct {
    logic        st;
    logic        sv;
    logic [7:0]  smp;
    logic        e_busy;
    logic        e_done;
    logic [15:0] e_hl;
    logic [7:0]  e_ref;
  } vec_t;

  vec_t tbl[8];

  initial begin
    rst = 1'b0; start = 1'b1; sample_valid = 1'b0; sample = 8'd0;

    // Reset held low with start asserted and random samples.
    for (int i = 0; i < 3; i++) begin
      sample_valid = 1'b1;
      sample = 8'($urandom_range(0, 255));
      step();
    end
    chk("reset_outputs", {b16, d16, to16, e16, hl16, rl16}, 0);
    chk("reset_outputs_cw4", {b4, d4, to4, e4, hl4, rl4}, 0);

    // Decay 200 -> 100 over five cycles; first start on the first released edge.
    tbl[0] = '{1'b1, 1'b0, 8'd0,   1'b1, 1'b0, 16'd0, 8'd0};
    tbl[1] = '{1'b0, 1'b1, 8'd200, 1'b1, 1'b0, 16'd0, 8'd200};
    tbl[2] = '{1'b0, 1'b1, 8'd190, 1'b1, 1'b0, 16'd0, 8'd200};
    tbl[3] = '{1'b0, 1'b1, 8'd170, 1'b1, 1'b0, 16'd0, 8'd200};
    tbl[4] = '{1'b0, 1'b1, 8'd150, 1'b1, 1'b0, 16'd0, 8'd200};
    tbl[5] = '{1'b0, 1'b1, 8'd120, 1'b1, 1'b0, 16'd0, 8'd200};
    tbl[6] = '{1'b0, 1'b1, 8'd100, 1'b0, 1'b1, 16'd5, 8'd200};
    tbl[7] = '{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 16'd5, 8'd200};
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].st, tbl[i].sv, tbl[i].smp);
      chk($sformatf("tbl%0d", i), {b16, d16, hl16, rl16, to16, e16},
          {tbl[i].e_busy, tbl[i].e_done, tbl[i].e_hl, tbl[i].e_ref, 2'b00});
    end

    // Odd reference 201: 101 is above threshold 100, 100 crosses.
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd201);
    drive(1'b0, 1'b1, 8'd101);
    chk("odd_no_cross_busy", b16, 1);
    drive(1'b0, 1'b1, 8'd100);
    chk("odd_cross", {d16, hl16, to16}, {1'b1, 16'd2, 1'b0});
    drive(1'b0, 1'b0, 8'd0);

    // Zero reference.
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd0);
    chk("zero_ref", {b16, d16, e16, to16, hl16}, {1'b0, 1'b1, 1'b1, 1'b0, 16'd0});
    drive(1'b0, 1'b0, 8'd0);
    chk("zero_ref_after", {b16, d16, e16}, {1'b0, 1'b0, 1'b1});

    // Saturation on the CW=4 instance with the level stuck at 40.
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd50);
    for (int i = 1; i <= 15; i++) drive(1'b0, 1'b1, 8'd40);
    chk("sat_timeout_cw4", {d4, to4, hl4}, {1'b1, 1'b1, 4'd15});
    chk("sat_cw16_still_busy", {b16, d16}, {1'b1, 1'b0});
    drive(1'b0, 1'b1, 8'd25);
    chk("cw16_late_cross", {d16, hl16, to16}, {1'b1, 16'd16, 1'b0});
    drive(1'b0, 1'b0, 8'd0);

    // Crossing on the saturation cycle wins.
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd50);
    for (int i = 1; i <= 14; i++) drive(1'b0, 1'b1, 8'd40);
    drive(1'b0, 1'b1, 8'd25);
    chk("sat_cross_cw4", {d4, to4, hl4}, {1'b1, 1'b0, 4'd15});
    chk("sat_cross_cw16", {d16, to16, hl16}, {1'b1, 1'b0, 16'd15});
    drive(1'b0, 1'b0, 8'd0);

    // Reset at elapsed 3 aborts without a done pulse.
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd100);
    drive(1'b0, 1'b1, 8'd90);
    drive(1'b0, 1'b1, 8'd90);
    rst = 1'b0;
    drive(1'b0, 1'b1, 8'd10);
    chk("abort_reset", {b16, d16, hl16}, 0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 8'd10);
    chk("abort_no_done", {b16, d16}, 0);

    // Start while measuring and while publishing is ignored.
    drive(1'b1, 1'b0, 8'd0);
    drive(1'b0, 1'b1, 8'd100);
    drive(1'b1, 1'b1, 8'd90);
    drive(1'b1, 1'b1, 8'd90);
    drive(1'b0, 1'b1, 8'd50);
    chk("ignore_start_hl", {d16, hl16}, {1'b1, 16'd3});
    drive(1'b1, 1'b0, 8'd0);
    chk("ignore_start_in_done", {b16, d16, hl16}, {1'b0, 1'b0, 16'd3});
    drive(1'b0, 1'b0, 8'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 5) == 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      sample = ($urandom_range(0, 19) == 0) ? 8'd0 : 8'($urandom_range(0, 255));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
